encoder_8to3_pend: RTL and testbench

- Companion to the 3-to-8 decoder: converts eight request lines back into a 3-bit binary code.
- Each x bit sets a sticky pending flag. The block presents one pending index at a time on y with valid/ready.
- The flag for an index clears when that index is accepted.
- Used wherever multiple decoded one-hot events must be funnelled back into a single coded stream, e.g. event or interrupt indexing.

---
 rtl/encoder_8to3_pend.sv | 92 +++++++++
 tb/tb_encoder_8to3_pend.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8to3_pend.sv
// Pending-request encoder: sticky per-line flags funnelled into one
// binary index at a time on a registered valid/ready output.
module encoder_8to3_pend #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] x,
    input  logic       ready,
    output logic [2:0] y,
    output logic       valid,
    output logic [7:0] pend
);

    logic [7:0] pend_q, pend_d;
    logic [2:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic [2:0] last_q, last_d;

    logic       acc;
    logic [7:0] clrMask;
    logic [7:0] setMask;
    logic [2:0] lastEff;
    logic [2:0] selIdx;

    // Highest set index wins; an empty vector yields 0.
    function automatic logic [2:0] selFixed(input logic [7:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) s = 3'(i);
        end
        return s;
    endfunction

    // Scan last-1, last-2, ... wrapping, ending at last itself.
    function automatic logic [2:0] selRotate(input logic [7:0] v, input logic [2:0] lastIdx);
        logic [2:0] s;
        logic [2:0] idx;
        logic       found;
        s     = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = lastIdx - 3'(k);
            if (!found && v[idx]) begin
                s     = idx;
                found = 1'b1;
            end
        end
        return s;
    endfunction

    // Set wins over clear, so a bit re-requested while being accepted is re-offered.
    always_comb begin
        acc     = valid_q & ready;
        clrMask = acc ? (8'h01 << y_q) : 8'h00;
        setMask = en ? x : 8'h00;
        pend_d  = (pend_q & ~clrMask) | setMask;
        lastEff = acc ? y_q : last_q;
        last_d  = lastEff;

        if (ROUND_ROBIN) selIdx = selRotate(pend_d, lastEff);
        else             selIdx = selFixed(pend_d);

        valid_d = valid_q;
        y_d     = y_q;
        if (!valid_q || acc) begin
            valid_d = |pend_d;
            y_d     = selIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 8'h00;
            y_q     <= 3'd0;
            valid_q <= 1'b0;
            last_q  <= 3'd0;
        end else begin
            pend_q  <= pend_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_encoder_8to3_pend.sv
// Drives a fixed-priority and a round-robin instance with identical stimulus
// and compares both against a cycle model plus hand-computed expectations.
module tb_encoder_8to3_pend;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] x = 8'h00;
    logic       ready = 1'b0;

    logic [2:0] yF, yR;
    logic       validF, validR;
    logic [7:0] pendF, pendR;

    int checksPassed = 0;
    int checksTotal  = 0;

    encoder_8to3_pend #(.ROUND_ROBIN(1'b0)) dutF (
        .clk(clk), .rst(rst), .en(en), .x(x), .ready(ready),
        .y(yF), .valid(validF), .pend(pendF)
    );

    encoder_8to3_pend #(.ROUND_ROBIN(1'b1)) dutR (
        .clk(clk), .rst(rst), .en(en), .x(x), .ready(ready),
        .y(yR), .valid(validR), .pend(pendR)
    );

    always #5 clk = ~clk;

    // Model state: index 0 is fixed priority, index 1 is round-robin.
    bit   mPend[2][8];
    int   mY[2];
    bit   mValid[2];
    int   mLast[2];
    bit   modelLive = 1'b0;

    function automatic int pickIndex(input bit v[8], input int lastIdx, input bit rr);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = rr ? ((lastIdx - k + 16) % 8) : (8 - k);
            if (v[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [7:0] packPend(input bit v[8]);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = v[i];
        return p;
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit nxt[8];
        bit any;
        int searchLast;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) mPend[m][i] = 1'b0;
                mY[m] = 0; mValid[m] = 1'b0; mLast[m] = 0;
            end else begin
                acc = mValid[m] && ready;
                any = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    nxt[i] = mPend[m][i];
                    if (acc && i == mY[m]) nxt[i] = 1'b0;
                    if (en && x[i]) nxt[i] = 1'b1;
                    any |= nxt[i];
                end
                searchLast = acc ? mY[m] : mLast[m];
                if (acc) mLast[m] = mY[m];
                if (!mValid[m] || acc) begin
                    mValid[m] = any;
                    mY[m] = pickIndex(nxt, searchLast, m == 1);
                end
                for (int i = 0; i < 8; i++) mPend[m][i] = nxt[i];
            end
        end
        if (rst) modelLive = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checksTotal++;
            if (yF === 3'(mY[0]) && validF === mValid[0] && pendF === packPend(mPend[0]))
                checksPassed++;
            else
                $display("[TB] FAIL modelFixed t=%0t: got y=%0d valid=%0b pend=%h, expected y=%0d valid=%0b pend=%h",
                         $time, yF, validF, pendF, mY[0], mValid[0], packPend(mPend[0]));
            checksTotal++;
            if (yR === 3'(mY[1]) && validR === mValid[1] && pendR === packPend(mPend[1]))
                checksPassed++;
            else
                $display("[TB] FAIL modelRR t=%0t: got y=%0d valid=%0b pend=%h, expected y=%0d valid=%0b pend=%h",
                         $time, yR, validR, pendR, mY[1], mValid[1], packPend(mPend[1]));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] xv, input logic rdy);
        @(negedge clk);
        rst = r; en = e; x = xv; ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit rr, input logic [2:0] expY,
                               input logic expValid, input logic [7:0] expPend);
        logic [2:0] gy;
        logic       gv;
        logic [7:0] gp;
        gy = rr ? yR : yF;
        gv = rr ? validR : validF;
        gp = rr ? pendR : pendF;
        checksTotal++;
        if (gy === expY && gv === expValid && gp === expPend)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got y=%0d valid=%0b pend=%h, expected y=%0d valid=%0b pend=%h",
                     name, gy, gv, gp, expY, expValid, expPend);
    endtask

    initial begin
        // Reset with requests active, then release.
        applyStimulus(1, 1, 8'hFF, 0);
        applyStimulus(1, 1, 8'hFF, 0);
        checkOutput("resetState", 0, 3'd0, 0, 8'h00);
        checkOutput("resetStateRR", 1, 3'd0, 0, 8'h00);
        applyStimulus(0, 1, 8'hFF, 0);
        checkOutput("afterReset", 0, 3'd7, 1, 8'hFF);

        // Fixed priority drain of A4.
        applyStimulus(1, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'hA4, 0);
        checkOutput("drain7", 0, 3'd7, 1, 8'hA4);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("drain5", 0, 3'd5, 1, 8'h24);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("drain2", 0, 3'd2, 1, 8'h04);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("drainEmpty", 0, 3'd0, 0, 8'h00);

        // Backpressure holds y while a higher request queues up.
        applyStimulus(0, 1, 8'h01, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h80, 0);
        checkOutput("backpressureMid", 0, 3'd0, 1, 8'h81);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("backpressureEnd", 0, 3'd0, 1, 8'h81);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("backpressureRelease", 0, 3'd7, 1, 8'h80);
        applyStimulus(0, 0, 8'h00, 1);

        // Accept and re-request of the same index in one cycle.
        applyStimulus(0, 1, 8'h08, 0);
        checkOutput("collisionSetup", 0, 3'd3, 1, 8'h08);
        applyStimulus(0, 1, 8'h08, 1);
        checkOutput("collision", 0, 3'd3, 1, 8'h08);
        applyStimulus(0, 0, 8'h00, 1);

        // Round-robin full sweep after reset, then 81 with last=0.
        applyStimulus(1, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'hFF, 1);
        checkOutput("rrSweep7", 1, 3'd7, 1, 8'hFF);
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkOutput($sformatf("rrSweep%0d", i), 1, 3'(i), 1, 8'hFF >> (7 - i));
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("rrSweepEmpty", 1, 3'd0, 0, 8'h00);
        applyStimulus(0, 1, 8'h81, 1);
        checkOutput("rr81first", 1, 3'd7, 1, 8'h81);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("rr81second", 1, 3'd0, 1, 8'h01);
        applyStimulus(0, 0, 8'h00, 1);

        // Enable gating, then reset while an offer is stalled.
        applyStimulus(0, 0, 8'hFF, 0);
        checkOutput("enGate", 0, 3'd0, 0, 8'h00);
        applyStimulus(0, 1, 8'h3C, 0);
        checkOutput("preReset", 0, 3'd5, 1, 8'h3C);
        applyStimulus(1, 1, 8'hFF, 1);
        checkOutput("midReset", 0, 3'd0, 0, 8'h00);
        checkOutput("midResetRR", 1, 3'd0, 0, 8'h00);

        // Random traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] xr;
            xr = 8'($urandom);
            if ($urandom_range(0, 2) != 0) xr = xr & 8'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, xr,
                          $urandom_range(0, 2) != 0);
        end
        applyStimulus(0, 0, 8'h00, 0);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
